rv32_pipe_ctrl: RTL

Pipeline hazard and stall controller for the RV32I five-stage core. Drives the stall/flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. Sources: load-use hazards against the EX stage, taken branches resolved in EX, and data-memory wait states. A watchdog halts the pipeline on a memory timeout. A saturating counter reports stall cycles for performance monitoring.

---
 rtl/rv32_pkg.sv | 17 +
 rtl/rv32_hazard_detect.sv | 25 ++
 rtl/rv32_pipe_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// rtl/rv32_pkg.sv - shared RV32I pipeline encodings
package rv32_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [2:0] WB_SEL_ALU = 3'd0;
  localparam logic [2:0] WB_SEL_MEM = 3'd1;
  localparam logic [2:0] WB_SEL_PC4 = 3'd2;
  localparam logic [2:0] WB_SEL_IMM = 3'd3;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/rv32_hazard_detect.sv
// rtl/rv32_hazard_detect.sv - combinational load-use compare between ID and EX
module rv32_hazard_detect
  import rv32_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs1_addr,
  input  logic [REG_ADDR_W-1:0] rs2_addr,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_rf_wr_en,
  input  logic [2:0]            ex_wb_mux_sel,
  output logic                  load_use
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a dependency
  assign ex_is_load = (ex_wb_mux_sel == WB_SEL_MEM) && ex_rf_wr_en && (ex_rd_addr != '0);
  assign rs1_hit    = rs1_used && (rs1_addr == ex_rd_addr);
  assign rs2_hit    = rs2_used && (rs2_addr == ex_rd_addr);
  assign load_use   = ex_is_load && (rs1_hit || rs2_hit);

endmodule

// File: rtl/rv32_pipe_ctrl.sv
// rtl/rv32_pipe_ctrl.sv - pipeline stall/flush controller with memory watchdog
module rv32_pipe_ctrl
  import rv32_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr_in,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr_in,
  input  logic                  id_rs1_used_in,
  input  logic                  id_rs2_used_in,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr_in,
  input  logic                  ex_rf_wr_en_in,
  input  logic [2:0]            ex_wb_mux_sel_in,
  input  logic                  branch_taken_in,
  input  logic                  mem_req_in,
  input  logic                  mem_ack_in,
  output logic                  pc_stall_out,
  output logic                  if_id_stall_out,
  output logic                  if_id_flush_out,
  output logic                  id_ex_stall_out,
  output logic                  id_ex_flush_out,
  output logic                  ex_mem_stall_out,
  output logic                  mem_wb_flush_out,
  output logic                  mem_err_out,
  output logic [1:0]            state_out,
  output logic [CNT_W-1:0]      stall_cnt_out
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT);

  pipe_state_t       state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              load_use;
  logic              mem_wait;

  assign mem_wait = mem_req_in && !mem_ack_in;

  rv32_hazard_detect u_hazard (
    .rs1_addr      (id_rs1_addr_in),
    .rs2_addr      (id_rs2_addr_in),
    .rs1_used      (id_rs1_used_in),
    .rs2_used      (id_rs2_used_in),
    .ex_rd_addr    (ex_rd_addr_in),
    .ex_rf_wr_en   (ex_rf_wr_en_in),
    .ex_wb_mux_sel (ex_wb_mux_sel_in),
    .load_use      (load_use)
  );

  always_comb begin
    pc_stall_out     = 1'b0;
    if_id_stall_out  = 1'b0;
    if_id_flush_out  = 1'b0;
    id_ex_stall_out  = 1'b0;
    id_ex_flush_out  = 1'b0;
    ex_mem_stall_out = 1'b0;
    mem_wb_flush_out = 1'b0;
    mem_err_out      = 1'b0;
    if (rst_in) begin
      pc_stall_out = 1'b0;
    end else if (state == HALT) begin
      pc_stall_out     = 1'b1;
      if_id_stall_out  = 1'b1;
      id_ex_stall_out  = 1'b1;
      ex_mem_stall_out = 1'b1;
      mem_wb_flush_out = 1'b1;
      mem_err_out      = 1'b1;
    end else if (mem_wait) begin
      // EX is frozen, so a pending branch or load-use is re-evaluated on release
      pc_stall_out     = 1'b1;
      if_id_stall_out  = 1'b1;
      id_ex_stall_out  = 1'b1;
      ex_mem_stall_out = 1'b1;
      mem_wb_flush_out = 1'b1;
    end else if (branch_taken_in) begin
      if_id_flush_out = 1'b1;
      id_ex_flush_out = 1'b1;
    end else if (load_use) begin
      pc_stall_out    = 1'b1;
      if_id_stall_out = 1'b1;
      id_ex_flush_out = 1'b1;
    end
  end

  assign state_out     = rst_in ? 2'd0 : state;
  assign stall_cnt_out = stall_cnt;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      if (pc_stall_out && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      case (state)
        RUN: begin
          if (mem_wait) begin
            state    <= MEM_WAIT;
            wait_cnt <= wait_cnt + 1'b1;
          end else begin
            wait_cnt <= '0;
          end
        end
        MEM_WAIT: begin
          if (!mem_wait) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            state    <= HALT;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: begin
          state    <= HALT;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule
